cnn_frame_sequencer: RTL and testbench
======================================

Name: cnn_frame_sequencer

Overview:
Frame-level controller for the CNN datapath (line buffer -> conv -> ReLU -> pool). On a start command it fetches a packed 8-bit image from memory over an OBI-style manager port. It streams the image one pixel per cycle into the line buffer, collects 32-bit results from the datapath tail and writes them back to an output buffer. It replaces per-pixel software polling: the register-file front end only programs bases and counts, pulses start and reads done/err.

Parameters:
ADDR_WIDTH, 32, memory address width
DATA_WIDTH, 8, pixel width; 4 pixels are packed per 32-bit word, little-endian
CNT_WIDTH, 16, width of the pixel and result counters

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; synchronous, active-high
start_i  in  1  start pulse; sampled only in IDLE or DONE
in_base_i  in  ADDR_WIDTH  image base address; word aligned
out_base_i  in  ADDR_WIDTH  result base address; word aligned
pix_count_i  in  CNT_WIDTH  total pixels to stream; must be >0
res_count_i  in  CNT_WIDTH  results expected and written
busy_o  out  1  high from start acceptance until DONE
done_o  out  1  high while in DONE
err_o  out  1  sticky bus error flag, cleared by the next start
mem_req_o  out  1  OBI request
mem_gnt_i  in  1  OBI grant
mem_we_o  out  1  write enable
mem_addr_o  out  ADDR_WIDTH  request address
mem_wdata_o  out  32  write data
mem_be_o  out  4  byte enables; always 4'hF
mem_rvalid_i  in  1  response valid
mem_rdata_i  in  32  read data
mem_err_i  in  1  response error; qualified by mem_rvalid_i
pix_o  out  DATA_WIDTH  pixel to the line buffer
pix_valid_o  out  1  pixel valid
pix_ready_i  in  1  line buffer ready; tie 1 if not used
res_data_i  in  32  datapath result
res_valid_i  in  1  result valid
res_ready_o  out  1  result accepted

Behaviour:
- Reset: state IDLE; all outputs 0 except mem_be_o = 4'hF; counters and holding registers cleared. Reset mid-frame aborts immediately. No bus transaction is completed after reset.
- Start: in IDLE or DONE, start_i latches the config, clears the counters and err_o, and moves to ARB the next cycle. Start while busy is ignored.
- States: IDLE, ARB, RD_REQ, RD_WAIT, STREAM, WR_REQ, WR_WAIT, DONE.
- At most one outstanding bus transaction. mem_req_o is held, with address, data and we stable, until mem_gnt_i is sampled high. The FSM then waits in *_WAIT for mem_rvalid_i. Grant and rvalid may arrive in the same cycle.
- Result holding register: one entry. res_ready_o = !hold_full && busy; a result is captured when res_valid_i && res_ready_o.
- ARB priority:
  - If hold_full, go to WR_REQ.
  - Else if words remain to read, go to RD_REQ.
  - Else if results_written == res_count_i, go to DONE.
  - Else stay in ARB and wait for a result.
- Writes therefore pre-empt reads, so the datapath never stalls on a full holding register for more than one transaction.
- RD_REQ: addr = in_base + 4*word_idx. On rvalid, the word is latched and the FSM goes to STREAM.
- STREAM: emits bytes [7:0] first. Each pix_valid_o && pix_ready_i handshake advances the byte and increments pix_sent. The FSM leaves after byte 3 or when pix_sent reaches pix_count_i, so a partial last word emits only the remaining bytes. It then returns to ARB.
- WR_REQ: addr = out_base + 4*res_idx; wdata = holding register. On rvalid, the holding register is cleared, res_idx increments, and the FSM returns to ARB.
- Read words needed = ceil(pix_count_i/4).
- Error: mem_err_i with mem_rvalid_i sets err_o and sends the FSM to DONE. Remaining pixels and results are abandoned, and a captured result is dropped.
- DONE: done_o = 1, busy_o = 0, res_ready_o = 0 until the next start or reset.
- Address arithmetic wraps modulo 2^ADDR_WIDTH. Counters never exceed their programmed totals.

Optional Feature:
CNN_SEQ_PERF_EN:
- Defined: adds output perf_cycles_o [31:0], counting cycles with busy_o high, and output perf_stall_o [31:0], counting cycles where mem_req_o && !mem_gnt_i. Both clear on start and saturate at 32'hFFFF_FFFF.
- Undefined: neither port nor logic exists.

Decomposition:
- Package cnn_seq_pkg: the state enum cnn_seq_state_e; BYTES_PER_WORD = 4; function words_for(pix) implementing the ceil division.
- Sub-module cnn_seq_unpack: 32-bit word to byte stream, with a byte index, a remaining-pixel limit and valid/ready. All other logic stays in the top module.

Test Plan:
- Zero-wait memory, pix_count=8, res_count=2, in_base=0x100, out_base=0x200. Expect reads at 0x100 and 0x104; pixels emitted in byte order 0..7; result 0x11 written to 0x200 and 0x22 to 0x204; done_o=1; err_o=0.
- pix_count=5. Expect 2 reads; exactly 5 pix_valid_o handshakes; bytes 1..3 of the second word are never emitted.
- Grant delayed 3 cycles and rvalid delayed 2 cycles. mem_addr_o and mem_req_o stay stable until grant; only one transaction is ever outstanding.
- Result presented during STREAM. It is captured; the next ARB issues the write before the following read, and res_ready_o stays 0 while the holding register is full.
- mem_err_i returned on the 2nd read. err_o=1 and done_o=1; no further requests; a new start clears err_o.
- start_i while busy: ignored. rst_i asserted mid-WR_WAIT: all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/cnn_seq_pkg.sv
// Shared types and helpers for the CNN frame sequencer.
// State encoding, pixel packing constants and word-count arithmetic.
package cnn_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_RD_REQ,
    S_RD_WAIT,
    S_STREAM,
    S_WR_REQ,
    S_WR_WAIT,
    S_DONE
  } cnn_seq_state_e;

  localparam int unsigned BYTES_PER_WORD = 4;

  // ceil(pix / 4) without an adder that could overflow
  function automatic logic [31:0] words_for(
    input logic [31:0] pix
  );
    return (pix >> 2) + {31'b0, |pix[1:0]};
  endfunction

endpackage

// File: rtl/cnn_seq_unpack.sv
// Splits one fetched 32-bit word into a little-endian pixel stream.
// Emits at most min(limit, 4) pixels, byte [7:0] first.
module cnn_seq_unpack
  import cnn_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    load_i,
  input  logic [4*DATA_WIDTH-1:0] word_i,
  input  logic [CNT_WIDTH-1:0]    limit_i,
  output logic [DATA_WIDTH-1:0]   pix_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic                    last_o
);

  logic [3:0][DATA_WIDTH-1:0] word_q;
  logic [1:0]                 idx_q;
  logic [2:0]                 cnt_q;
  logic                       active_q;
  logic                       fire;

  assign pix_o   = word_q[idx_q];
  assign valid_o = active_q;
  assign last_o  = active_q && ({1'b0, idx_q} == cnt_q - 3'd1);
  assign fire    = active_q && ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      word_q   <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (load_i) begin
      word_q   <= word_i;
      idx_q    <= '0;
      active_q <= (limit_i != '0);
      if (limit_i >= CNT_WIDTH'(BYTES_PER_WORD))
        cnt_q <= 3'd4;
      else
        cnt_q <= limit_i[2:0];
    end else if (fire) begin
      idx_q <= idx_q + 2'd1;
      if (last_o)
        active_q <= 1'b0;
    end
  end

endmodule

// File: rtl/cnn_frame_sequencer.sv
// Frame controller: fetch packed image, stream pixels, write results.
// Optional CNN_SEQ_PERF_EN adds busy-cycle and bus-stall counters.
module cnn_frame_sequencer
  import cnn_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] in_base_i,
  input  logic [ADDR_WIDTH-1:0] out_base_i,
  input  logic [CNT_WIDTH-1:0]  pix_count_i,
  input  logic [CNT_WIDTH-1:0]  res_count_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  mem_req_o,
  input  logic                  mem_gnt_i,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  output logic [3:0]            mem_be_o,
  input  logic                  mem_rvalid_i,
  input  logic [31:0]           mem_rdata_i,
  input  logic                  mem_err_i,
  output logic [DATA_WIDTH-1:0] pix_o,
  output logic                  pix_valid_o,
  input  logic                  pix_ready_i,
  input  logic [31:0]           res_data_i,
  input  logic                  res_valid_i,
  output logic                  res_ready_o
`ifdef CNN_SEQ_PERF_EN
  ,
  output logic [31:0]           perf_cycles_o,
  output logic [31:0]           perf_stall_o
`endif
);

  cnn_seq_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] in_base_q;
  logic [ADDR_WIDTH-1:0] out_base_q;
  logic [CNT_WIDTH-1:0]  pix_cnt_q;
  logic [CNT_WIDTH-1:0]  res_cnt_q;
  logic [CNT_WIDTH-1:0]  word_idx_q;
  logic [CNT_WIDTH-1:0]  res_idx_q;
  logic [CNT_WIDTH-1:0]  pix_sent_q;
  logic [31:0]           hold_q;
  logic                  hold_full_q;
  logic                  err_q;

  logic        start_ok;
  logic [31:0] words_total;
  logic        rd_more;
  logic        rsp_rd;
  logic        rsp_wr;
  logic        rsp_err;
  logic        rd_ok;
  logic        wr_ok;
  logic        pix_fire;
  logic        pix_last;
  logic        unpack_last;
  logic        res_take;

  assign start_ok = start_i &&
    (state_q == S_IDLE || state_q == S_DONE);

  assign words_total = words_for(32'(pix_cnt_q));
  assign rd_more = 32'(word_idx_q) < words_total;

  // grant and response may coincide in the *_REQ state
  assign rsp_rd = mem_rvalid_i &&
    ((state_q == S_RD_REQ && mem_gnt_i) ||
     state_q == S_RD_WAIT);
  assign rsp_wr = mem_rvalid_i &&
    ((state_q == S_WR_REQ && mem_gnt_i) ||
     state_q == S_WR_WAIT);
  assign rsp_err  = (rsp_rd || rsp_wr) && mem_err_i;
  assign rd_ok    = rsp_rd && !mem_err_i;
  assign wr_ok    = rsp_wr && !mem_err_i;
  assign pix_fire = pix_valid_o && pix_ready_i;
  assign pix_last = pix_fire && unpack_last;
  assign res_take = res_valid_i && res_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i)
          state_d = S_ARB;
      end
      S_ARB: begin
        if (hold_full_q)
          state_d = S_WR_REQ;
        else if (rd_more)
          state_d = S_RD_REQ;
        else if (res_idx_q == res_cnt_q)
          state_d = S_DONE;
      end
      S_RD_REQ: begin
        if (mem_gnt_i) begin
          if (rsp_err)
            state_d = S_DONE;
          else if (rsp_rd)
            state_d = S_STREAM;
          else
            state_d = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (rsp_rd)
          state_d = mem_err_i ? S_DONE : S_STREAM;
      end
      S_STREAM: begin
        if (pix_last)
          state_d = S_ARB;
      end
      S_WR_REQ: begin
        if (mem_gnt_i) begin
          if (rsp_err)
            state_d = S_DONE;
          else if (rsp_wr)
            state_d = S_ARB;
          else
            state_d = S_WR_WAIT;
        end
      end
      S_WR_WAIT: begin
        if (rsp_wr)
          state_d = mem_err_i ? S_DONE : S_ARB;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o      = 1'b0;
    done_o      = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    unique case (1'b1)
      state_q == S_IDLE: ;
      state_q == S_DONE: done_o = 1'b1;
      state_q == S_RD_REQ: begin
        busy_o     = 1'b1;
        mem_req_o  = 1'b1;
        mem_addr_o = in_base_q +
          (ADDR_WIDTH'(word_idx_q) << 2);
      end
      state_q == S_WR_REQ: begin
        busy_o      = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = out_base_q +
          (ADDR_WIDTH'(res_idx_q) << 2);
        mem_wdata_o = hold_q;
      end
      default: busy_o = 1'b1;
    endcase
    err_o       = err_q;
    mem_be_o    = 4'hF;
    res_ready_o = !hold_full_q && busy_o;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      in_base_q   <= '0;
      out_base_q  <= '0;
      pix_cnt_q   <= '0;
      res_cnt_q   <= '0;
      word_idx_q  <= '0;
      res_idx_q   <= '0;
      pix_sent_q  <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      err_q       <= 1'b0;
    end else if (start_ok) begin
      in_base_q   <= in_base_i;
      out_base_q  <= out_base_i;
      pix_cnt_q   <= pix_count_i;
      res_cnt_q   <= res_count_i;
      word_idx_q  <= '0;
      res_idx_q   <= '0;
      pix_sent_q  <= '0;
      hold_full_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (rd_ok)
        word_idx_q <= word_idx_q + 1'b1;
      if (pix_fire)
        pix_sent_q <= pix_sent_q + 1'b1;
      if (wr_ok) begin
        hold_full_q <= 1'b0;
        res_idx_q   <= res_idx_q + 1'b1;
      end else if (res_take) begin
        hold_full_q <= 1'b1;
        hold_q      <= res_data_i;
      end
      // a bus error abandons the frame, including any held result
      if (rsp_err) begin
        err_q       <= 1'b1;
        hold_full_q <= 1'b0;
      end
    end
  end

  cnn_seq_unpack #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_unpack (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (rd_ok),
    .word_i  (mem_rdata_i[4*DATA_WIDTH-1:0]),
    .limit_i (pix_cnt_q - pix_sent_q),
    .pix_o   (pix_o),
    .valid_o (pix_valid_o),
    .ready_i (pix_ready_i),
    .last_o  (unpack_last)
  );

`ifdef CNN_SEQ_PERF_EN
  logic [31:0] perf_cyc_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || start_ok) begin
      perf_cyc_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      if (busy_o && perf_cyc_q != '1)
        perf_cyc_q <= perf_cyc_q + 32'd1;
      if (mem_req_o && !mem_gnt_i &&
          perf_stall_q != '1)
        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_cycles_o = perf_cyc_q;
  assign perf_stall_o  = perf_stall_q;
`endif

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Self-checking bench for cnn_frame_sequencer.
// Memory/datapath models plus a per-cycle compare against frame plans.
module tb_cnn_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [31:0] in_base_i;
  logic [31:0] out_base_i;
  logic [15:0] pix_count_i;
  logic [15:0] res_count_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic        mem_req_o;
  logic        mem_gnt_i;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        mem_err_i;
  logic [7:0]  pix_o;
  logic        pix_valid_o;
  logic        pix_ready_i;
  logic [31:0] res_data_i;
  logic        res_valid_i;
  logic        res_ready_o;
`ifdef CNN_SEQ_PERF_EN
  logic [31:0] perf_cycles_o;
  logic [31:0] perf_stall_o;
`endif

  always #5 clk = ~clk;

  cnn_frame_sequencer dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .in_base_i    (in_base_i),
    .out_base_i   (out_base_i),
    .pix_count_i  (pix_count_i),
    .res_count_i  (res_count_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .mem_req_o    (mem_req_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_be_o     (mem_be_o),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .mem_err_i    (mem_err_i),
    .pix_o        (pix_o),
    .pix_valid_o  (pix_valid_o),
    .pix_ready_i  (pix_ready_i),
    .res_data_i   (res_data_i),
    .res_valid_i  (res_valid_i),
    .res_ready_o  (res_ready_o)
`ifdef CNN_SEQ_PERF_EN
    ,
    .perf_cycles_o (perf_cycles_o),
    .perf_stall_o  (perf_stall_o)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // frame plan (expected traffic) and observation logs
  logic [31:0] exp_rd[$];
  logic [7:0]  exp_pix[$];
  logic [63:0] exp_wr[$];
  logic [31:0] res_q[$];
  logic [31:0] rd_log[$];
  logic [7:0]  pix_log[$];
  logic [63:0] wr_log[$];
  bit          kind_log[$];
  int          exp_npix;
  bit          exp_err;
  int          rd_base, pix_base, wr_base, kind_base;

  // memory / datapath model knobs
  int gdly = 0;
  int rdly = 0;
  int err_rd = 0;
  bit res_gate = 0;
  bit pix_toggle = 0;

  // memory / datapath model state
  int          cyc = 0;
  int          age = 0;
  bit          pend = 0;
  int          pend_wait = 0;
  logic [31:0] pend_data;
  bit          pend_err = 0;
  bit          pend_we = 0;
  int          rd_num = 0;
  int          wr_grants = 0;
  bit          prev_wait = 0;
  logic [31:0] prev_addr, prev_wdata;
  logic        prev_we;
  bit          cap_pend = 0;

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    logic [31:0] w, x;
    w = '0;
    for (int b = 0; b < 4; b++) begin
      x = a + 32'(b);
      w[8*b +: 8] = x[7:0];
    end
    return w;
  endfunction

  task automatic respond();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = pend_data;
    mem_err_i    = pend_err;
    if (pend_err || pend_we)
      cap_pend = 0;
  endtask

  task automatic record_grant();
    if (mem_we_o) begin
      wr_grants++;
      kind_log.push_back(1'b1);
      wr_log.push_back({mem_addr_o, mem_wdata_o});
      if (exp_wr.size() == 0)
        chk("wr_extra", 1, 0);
      else begin
        logic [63:0] e;
        e = exp_wr.pop_front();
        chk("wr_addr", mem_addr_o, e[63:32]);
        chk("wr_data", mem_wdata_o, e[31:0]);
      end
      pend_data = '0;
      pend_err  = 0;
      pend_we   = 1;
    end else begin
      rd_num++;
      kind_log.push_back(1'b0);
      rd_log.push_back(mem_addr_o);
      if (exp_rd.size() == 0)
        chk("rd_extra", 1, 0);
      else
        chk("rd_addr", mem_addr_o, exp_rd.pop_front());
      pend_data = rd_word(mem_addr_o);
      pend_err  = (rd_num == err_rd);
      pend_we   = 0;
    end
  endtask

  // compare process and bus/datapath models; decisions made here
  // take effect at the following rising edge
  always @(negedge clk) begin
    cyc++;
    chk("be_const", mem_be_o, 4'hF);
    if (cap_pend)
      chk("res_ready_full", res_ready_o, 0);
    if (pend)
      chk("one_outstanding", mem_req_o, 0);
    if (done_o)
      chk("idle_bus_done", mem_req_o, 0);
    if (prev_wait) begin
      chk("req_held", mem_req_o, 1);
      chk("addr_stable", mem_addr_o, prev_addr);
      chk("we_stable", mem_we_o, prev_we);
      chk("wdata_stable", mem_wdata_o, prev_wdata);
    end
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_err_i    = 1'b0;
    mem_rdata_i  = '0;
    pix_ready_i  = pix_toggle ? ((cyc % 2) == 0) : 1'b1;
    res_valid_i  = 1'b0;
    res_data_i   = '0;
    if (rst_i) begin
      pend      = 0;
      prev_wait = 0;
      age       = 0;
      cap_pend  = 0;
    end else begin
      if (pend) begin
        if (pend_wait == 0) begin
          respond();
          pend = 0;
        end else
          pend_wait--;
      end else if (mem_req_o) begin
        if (age >= gdly) begin
          mem_gnt_i = 1'b1;
          age = 0;
          record_grant();
          if (rdly == 0)
            respond();
          else begin
            pend = 1;
            pend_wait = rdly - 1;
          end
        end else
          age++;
      end
      prev_wait  = mem_req_o && !mem_gnt_i;
      prev_addr  = mem_addr_o;
      prev_we    = mem_we_o;
      prev_wdata = mem_wdata_o;
      if (pix_valid_o && pix_ready_i) begin
        pix_log.push_back(pix_o);
        if (exp_pix.size() == 0)
          chk("pix_extra", 1, 0);
        else
          chk("pix_data", pix_o, exp_pix.pop_front());
      end
      if (res_q.size() > 0 && (!res_gate || pix_valid_o)) begin
        res_valid_i = 1'b1;
        res_data_i  = res_q[0];
        if (res_ready_o) begin
          void'(res_q.pop_front());
          cap_pend = 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic plan(input int pix, input int res,
                      input logic [31:0] ib,
                      input logic [31:0] ob,
                      input int erd);
    int words, nread, good, npix;
    logic [31:0] a;
    words = (pix + 3) / 4;
    nread = words;
    good  = words;
    if (erd > 0 && erd <= words) begin
      nread = erd;
      good  = erd - 1;
    end
    exp_rd.delete();
    exp_pix.delete();
    exp_wr.delete();
    for (int k = 0; k < nread; k++)
      exp_rd.push_back(ib + 32'(4 * k));
    npix = (pix < 4 * good) ? pix : 4 * good;
    for (int i = 0; i < npix; i++) begin
      a = ib + 32'(i);
      exp_pix.push_back(a[7:0]);
    end
    if (nread == good)
      for (int j = 0; j < res; j++)
        exp_wr.push_back({ob + 32'(4 * j), res_q[j]});
    exp_npix  = npix;
    exp_err   = (nread != good);
    rd_base   = rd_log.size();
    pix_base  = pix_log.size();
    wr_base   = wr_log.size();
    kind_base = kind_log.size();
  endtask

  task automatic start_frame(input int pix, input int res,
                             input logic [31:0] ib,
                             input logic [31:0] ob,
                             input int erd);
    plan(pix, res, ib, ob, erd);
    err_rd      = (erd > 0) ? rd_num + erd : 0;
    in_base_i   = ib;
    out_base_i  = ob;
    pix_count_i = 16'(pix);
    res_count_i = 16'(res);
    start_i     = 1'b1;
    tick();
    start_i     = 1'b0;
  endtask

  task automatic end_frame();
    for (int i = 0; i < 600; i++) begin
      if (done_o)
        break;
      tick();
    end
    chk("done_reached", done_o, 1);
    chk("err_flag", err_o, exp_err);
    chk("busy_in_done", busy_o, 0);
    chk("rd_left", exp_rd.size(), 0);
    chk("pix_left", exp_pix.size(), 0);
    chk("wr_left", exp_wr.size(), 0);
    chk("pix_count", pix_log.size() - pix_base, exp_npix);
    repeat (3) tick();
  endtask

  task automatic check_reset_outputs();
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_req", mem_req_o, 0);
    chk("rst_we", mem_we_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_wdata", mem_wdata_o, 0);
    chk("rst_be", mem_be_o, 4'hF);
    chk("rst_pix", pix_o, 0);
    chk("rst_pix_valid", pix_valid_o, 0);
    chk("rst_res_ready", res_ready_o, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    int base;
    logic [3:0] kinds;
    rst_i       = 1'b1;
    start_i     = 1'b0;
    in_base_i   = '0;
    out_base_i  = '0;
    pix_count_i = '0;
    res_count_i = '0;
    repeat (3) tick();
    check_reset_outputs();
    rst_i = 1'b0;
    tick();

    // basic frame, zero-wait memory
    res_q = '{32'h11, 32'h22};
    start_frame(8, 2, 32'h100, 32'h200, 0);
    end_frame();
    chk("t1_rd0", rd_log[rd_base], 32'h100);
    chk("t1_rd1", rd_log[rd_base+1], 32'h104);
    chk("t1_pix0", pix_log[pix_base], 8'h00);
    chk("t1_pix7", pix_log[pix_base+7], 8'h07);
    chk("t1_wr0", wr_log[wr_base], {32'h200, 32'h11});
    chk("t1_wr1", wr_log[wr_base+1], {32'h204, 32'h22});

    // partial last word
    res_q = '{32'h33};
    start_frame(5, 1, 32'h1000, 32'h2000, 0);
    end_frame();
    chk("t2_reads", rd_log.size() - rd_base, 2);
    chk("t2_pix4", pix_log[pix_base+4], 8'h04);

    // slow grant/response, stalled line buffer, address wrap
    gdly = 3;
    rdly = 2;
    pix_toggle = 1;
    res_q = '{32'hCAFE_0001};
    start_frame(6, 1, 32'hFFFF_FFFC, 32'h300, 0);
    end_frame();
    chk("t3_rd_wrap", rd_log[rd_base+1], 32'h0);
    chk("t3_pix3", pix_log[pix_base+3], 8'hFF);
    chk("t3_pix4", pix_log[pix_base+4], 8'h00);
    gdly = 0;
    rdly = 0;
    pix_toggle = 0;

    // results arriving mid-stream pre-empt the next read
    res_gate = 1;
    res_q = '{32'hA1, 32'hA2};
    start_frame(8, 2, 32'h100, 32'h200, 0);
    end_frame();
    chk("t4_txns", kind_log.size() - kind_base, 4);
    kinds = '0;
    for (int i = 0; i < 4 && kind_base + i < kind_log.size(); i++)
      kinds[3-i] = kind_log[kind_base+i];
    chk("t4_order", kinds, 4'b0101);
    res_gate = 0;

    // bus error on second read, then restart clears err
    res_q.delete();
    start_frame(8, 2, 32'h100, 32'h200, 2);
    end_frame();
    chk("t5_err", err_o, 1);
    chk("t5_done", done_o, 1);
    err_rd = 0;
    res_q = '{32'h77};
    start_frame(4, 1, 32'h100, 32'h200, 0);
    chk("t5_err_cleared", err_o, 0);
    chk("t5_busy", busy_o, 1);
    end_frame();

    // start while busy is ignored
    res_q = '{32'h44};
    start_frame(4, 1, 32'h400, 32'h500, 0);
    tick();
    in_base_i   = 32'h900;
    out_base_i  = 32'hA00;
    pix_count_i = 16'd12;
    start_i     = 1'b1;
    tick();
    start_i     = 1'b0;
    chk("t6_busy", busy_o, 1);
    end_frame();

    // reset while waiting for a write response
    rdly = 5;
    res_q = '{32'h55};
    start_frame(4, 1, 32'h600, 32'h700, 0);
    base = wr_grants;
    for (int i = 0; i < 300; i++) begin
      if (wr_grants > base)
        break;
      tick();
    end
    chk("t6_wr_granted", wr_grants > base, 1);
    rst_i = 1'b1;
    tick();
    check_reset_outputs();
    rst_i = 1'b0;
    rdly = 0;
    exp_rd.delete();
    exp_pix.delete();
    exp_wr.delete();
    res_q.delete();
    repeat (3) tick();
    chk("t6_idle_busy", busy_o, 0);
    chk("t6_idle_req", mem_req_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
